// File: rtl/a_seq_arbiter.sv
// a_seq_arbiter: round-robin arbiter and sequencer that walks the A/K1/K2
// control FSM through START, STOP and CLEAR for one requester at a time,
// confirms K2, returns the FSM to IDLE and reports done or error.
module a_seq_arbiter #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic [1:0]       req_i,
   input  logic [CNT_W-1:0] t_start_i,
   input  logic [CNT_W-1:0] t_stop_i,
   input  logic [CNT_W-1:0] t_clear_i,
   input  logic             k2_i,
   output logic             A_o,
   output logic [1:0]       gnt_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PH1,
      S_PH2,
      S_PH3,
      S_CHK,
      S_REL,
      S_FIN
   } state_e;

   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] t_stop_q, t_stop_d;
   logic [CNT_W-1:0] t_clear_q, t_clear_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic             sticky_q, sticky_d;
   logic             ok_q, ok_d;
   logic             a_q, a_d;
   logic [1:0]       gnt_q, gnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             winner;

   // A zero phase length is treated as a single cycle so no phase can wrap.
   function automatic logic [CNT_W-1:0] fixLen(input logic [CNT_W-1:0] t);
      return (t == '0) ? CNT_ONE : t;
   endfunction

   // State register plus all registered outputs; last_q resets to requester 1
   // so requester 0 is favoured first.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         t_stop_q  <= '0;
         t_clear_q <= '0;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         sticky_q  <= 1'b0;
         ok_q      <= 1'b0;
         a_q       <= 1'b0;
         gnt_q     <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         t_stop_q  <= t_stop_d;
         t_clear_q <= t_clear_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         sticky_q  <= sticky_d;
         ok_q      <= ok_d;
         a_q       <= a_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic: arbitration in IDLE, phase countdowns, K2 check with timeout.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      t_stop_d  = t_stop_q;
      t_clear_d = t_clear_q;
      owner_d   = owner_q;
      last_d    = last_q;
      sticky_d  = sticky_q;
      ok_d      = ok_q;
      winner    = (req_i == 2'b11) ? ~last_q : req_i[1];
      unique case (state_q)
         S_IDLE: begin
            if (req_i != 2'b00) begin
               owner_d   = winner;
               cnt_d     = fixLen(t_start_i);
               t_stop_d  = fixLen(t_stop_i);
               t_clear_d = fixLen(t_clear_i);
               sticky_d  = 1'b0;
               ok_d      = 1'b0;
               state_d   = S_PH1;
            end
         end
         S_PH1: begin
            if (cnt_q == CNT_ONE) begin
               cnt_d   = t_stop_q;
               state_d = S_PH2;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_PH2: begin
            if (cnt_q == CNT_ONE) begin
               cnt_d   = t_clear_q;
               state_d = S_PH3;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_PH3: begin
            if (k2_i) begin
               sticky_d = 1'b1;
            end
            if (cnt_q == CNT_ONE) begin
               cnt_d   = TIMEOUT_LOAD;
               state_d = S_CHK;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_CHK: begin
            if (k2_i || sticky_q) begin
               ok_d    = 1'b1;
               state_d = S_REL;
            end else if (cnt_q == CNT_ONE) begin
               ok_d    = 1'b0;
               state_d = S_REL;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_REL: begin
            state_d = S_FIN;
         end
         S_FIN: begin
            last_d   = owner_q;
            sticky_d = 1'b0;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output is a flop aligned with its state.
   always_comb begin
      a_d    = (state_d == S_PH1) || (state_d == S_PH3) || (state_d == S_CHK);
      busy_d = (state_d != S_IDLE);
      gnt_d  = 2'b00;
      if (state_d != S_IDLE) begin
         gnt_d = owner_d ? 2'b10 : 2'b01;
      end
      done_d = (state_d == S_FIN) && ok_d;
      err_d  = (state_d == S_FIN) && !ok_d;
   end

   assign A_o    = a_q;
   assign gnt_o  = gnt_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign err_o  = err_q;

endmodule
